hist_cdf_builder: RTL and testbench
===================================

Name: hist_cdf_builder

Overview:
- Producer side of histogram equalization: accumulates a 256-bin luma histogram over one 320x240 frame (76800 pixels), then prefix-sums it into a CDF.
- Serves random-access CDF lookups plus cdf_min to the equalization mapper, which turns each cdf into an output pixel.
- Sits between the pixel source (decoder output) and the equalization mapper.

Parameters:
- PIXELS, 76800, pixels per frame; ends the ACCUM phase.
- BINS, 256, histogram bins; the pixel value is the bin index.
- CNT_W, 17, width of bin counts and CDF values; must satisfy 2^CNT_W > PIXELS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel input valid
- pix_ready  out  1  block accepts pixel this cycle
- pix_in  in  8  pixel luma value
- lut_req  in  1  CDF lookup request (READY state only)
- lut_addr  in  8  bin to look up
- lut_vld  out  1  lookup result valid, one cycle after lut_req
- cdf_out  out  CNT_W  CDF value of lut_addr
- cdf_min  out  CNT_W  first nonzero CDF value of the frame
- cdf_rdy  out  1  CDF table and cdf_min valid
- release  in  1  pulse: consumer done, start next frame

Behaviour:
- Reset (async, rst_n low):
  - State = CLEAR, bin index = 0.
  - pix_ready = 0, lut_vld = 0, cdf_out = 0, cdf_min = 0, cdf_rdy = 0.
  - Histogram contents are don't-care; CLEAR zeroes them.
- CLEAR: writes 0 to one bin per cycle. After 256 cycles -> ACCUM, pixel counter = 0.
- ACCUM:
  - pix_ready = 1. A pixel is accepted when pix_valid & pix_ready.
  - Two-stage read-modify-write: read bin in cycle t, write count+1 in cycle t+1.
  - A same-bin pixel accepted in cycle t+1 uses the forwarded value, not the stale array value. No stalls: one pixel per cycle sustained.
  - When the pixel counter reaches PIXELS-1 and that pixel is accepted, pix_ready drops in the next cycle. The last write drains, then -> SCAN.
- SCAN:
  - One bin per cycle, index 0..255: running += hist[i]; hist[i] <= running (CDF stored in place).
  - cdf_min latches the running value at the first bin whose hist[i] != 0, via a found flag.
  - After bin 255 -> READY.
  - Total = PIXELS guarantees cdf of bin 255 == PIXELS, with no overflow at CNT_W = 17.
- READY:
  - cdf_rdy = 1.
  - lut_req samples lut_addr; next cycle lut_vld = 1 and cdf_out = CDF[lut_addr]. Back-to-back requests are fully pipelined.
  - lut_req outside READY is ignored and lut_vld stays 0.
  - release -> CLEAR: cdf_rdy = 0 next cycle, and cdf_min holds its value until the next SCAN writes it.
  - release together with lut_req: the lookup completes (lut_vld the next cycle), then CLEAR.
- release outside READY is ignored.
- pix_valid outside ACCUM is not accepted; the source holds the pixel.
- Reset mid-frame: the partial histogram is discarded and the block restarts at CLEAR.
- Frame cycle count: 256 + PIXELS + drain + 256 + lookup time.

Optional Feature:
- Macro HIST_BIN_OUT_EN.
- When defined:
  - Adds output bin_cnt_out (CNT_W), valid with lut_vld, giving the raw histogram count of lut_addr.
  - SCAN keeps raw counts in a second array instead of overwriting them, doubling storage.
- When undefined: no extra port; the histogram is overwritten in place by the CDF.

Decomposition:
- Shared package holds:
  - Constants: FRAME_W = 320, FRAME_H = 240, PIXELS, BINS, CNT_W.
  - State enum: CLEAR, ACCUM, SCAN, READY.
  - Typedef cnt_t.
- One natural sub-module, hist_ram: BINS x CNT_W array with one synchronous read port and one write port, read-before-write. Under HIST_BIN_OUT_EN it is instantiated twice.

Test Plan:
- Reset, then 76800 pixels all value 100 -> cdf_min = 76800; CDF[99] = 0, CDF[100] = 76800, CDF[255] = 76800.
- Pixel value = index mod 256 for 76800 pixels -> each bin 300; CDF[k] = 300*(k+1), cdf_min = 300.
- Alternating back-to-back 7,7,7,8 repeated -> CDF[7] = 57600, CDF[8] = 76800 (checks forwarding).
- pix_valid held high throughout -> exactly 76800 handshakes; pix_ready = 0 in the cycle after the last accept; cdf_rdy rises after 256 SCAN cycles.
- In READY, lut_req with addrs 0, 255, 100 on consecutive cycles -> lut_vld high for 3 consecutive cycles with matching values; release then frame 2 with all pixels = 0 -> cdf_min = 76800.
- Assert rst_n low mid-ACCUM (pixel 40000), then a full frame of value 50 -> CDF[49] = 0, CDF[50] = 76800 (no residue from the aborted frame).

Source files
------------

// File: rtl/hist_cdf_builder_pkg.sv
// Shared constants, counter type and FSM encoding for the histogram/CDF builder.
package hist_cdf_builder_pkg;

  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int PIXELS  = FRAME_W * FRAME_H;
  localparam int BINS    = 256;
  localparam int CNT_W   = 17;

  typedef logic [CNT_W-1:0] cnt_t;

  // Frame phases: CLEAR -> ACCUM -> SCAN -> READY -> CLEAR
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

endpackage

// File: rtl/hist_cdf_builder_ram.sv
// BINS x CNT_W storage: one registered read port, one write port.
// A read and a write to the same bin in one cycle return the old contents;
// the owner forwards around that.
module hist_ram
  import hist_cdf_builder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data
);

  cnt_t mem [BINS];

  // Write port; array contents are not reset (CLEAR phase zeroes them)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, sees the array before this cycle's write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hist_cdf_builder.sv
// Histogram accumulator and in-place CDF builder for one luma frame.
// Optional build macro HIST_BIN_OUT_EN adds bin_cnt_out with the raw bin
// count, kept in a second hist_ram that SCAN does not overwrite.
// The consumer-done pulse is named frame_release because "release" is a
// reserved word. state_dbg exposes the FSM state for checkers.
//
// Handshake: a pixel transfers on a rising edge where pix_valid and
// pix_ready are both 1; pix_ready depends only on registered state, never on
// pix_valid, and the source must hold pix_in/pix_valid until the transfer.
module hist_cdf_builder
  import hist_cdf_builder_pkg::*;
#(
  parameter int FRAME_PIXELS = PIXELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_in,
  input  logic             lut_req,
  input  logic [7:0]       lut_addr,
  output logic             lut_vld,
  output logic [CNT_W-1:0] cdf_out,
  output logic [CNT_W-1:0] cdf_min,
  output logic             cdf_rdy,
  input  logic             frame_release,
`ifdef HIST_BIN_OUT_EN
  output logic [CNT_W-1:0] bin_cnt_out,
`endif
  output logic [1:0]       state_dbg
);

  localparam cnt_t LAST_PIX = cnt_t'(FRAME_PIXELS - 1);

  logic [1:0] state;
  logic [7:0] idx;          // CLEAR/SCAN bin index
  cnt_t       pix_cnt;
  logic       accum_done;   // last pixel taken, its write drains this cycle
  cnt_t       running;
  logic       found;

  // Accumulate pipeline (read issued last cycle, write this cycle)
  logic       s1_valid;
  logic [7:0] s1_addr;

  // Record of the previous cycle's write, for read-after-write forwarding
  logic       last_we;
  logic [7:0] last_addr;
  cnt_t       last_data;

  logic [7:0] rd_addr, wr_addr, cur_addr;
  cnt_t       rd_data, wr_data, base, sum;
  logic       wr_en, accept;

  assign pix_ready = (state == ST_ACCUM) && !accum_done;
  assign accept    = pix_valid && pix_ready;
  assign cdf_rdy   = (state == ST_READY);
  assign state_dbg = state;

  // Stage-2 bin: the pixel bin in ACCUM, the scan index in SCAN
  assign cur_addr = (state == ST_SCAN) ? idx : s1_addr;
  // The array read missed last cycle's write to the same bin; use that value
  assign base = (last_we && (last_addr == cur_addr)) ? last_data : rd_data;
  assign sum  = running + base;

  // Memory port steering per phase
  always_comb begin
    rd_addr = lut_addr;
    wr_en   = 1'b0;
    wr_addr = cur_addr;
    wr_data = '0;
    case (state)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx;
      end
      ST_ACCUM: begin
        // In the drain cycle prefetch bin 0 so SCAN covers 256 cycles flat
        rd_addr = accum_done ? 8'd0 : pix_in;
        wr_en   = s1_valid;
        wr_data = base + cnt_t'(1);
      end
      ST_SCAN: begin
        rd_addr = idx + 8'd1;
        wr_en   = 1'b1;
        wr_data = sum;
      end
      default: rd_addr = lut_addr;
    endcase
  end

  hist_ram u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Phase FSM with bin index, pixel counter and prefix-sum state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      idx        <= 8'd0;
      pix_cnt    <= '0;
      accum_done <= 1'b0;
      running    <= '0;
      found      <= 1'b0;
      cdf_min    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state      <= ST_ACCUM;
            pix_cnt    <= '0;
            accum_done <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            pix_cnt <= pix_cnt + cnt_t'(1);
            if (pix_cnt == LAST_PIX) accum_done <= 1'b1;
          end
          if (accum_done) begin
            state      <= ST_SCAN;
            idx        <= 8'd0;
            running    <= '0;
            found      <= 1'b0;
            accum_done <= 1'b0;
          end
        end
        ST_SCAN: begin
          idx     <= idx + 8'd1;
          running <= sum;
          if (!found && (base != '0)) begin
            found   <= 1'b1;
            cdf_min <= sum;
          end
          if (idx == 8'hFF) state <= ST_READY;
        end
        default: begin
          if (frame_release) begin
            state <= ST_CLEAR;
            idx   <= 8'd0;
          end
        end
      endcase
    end
  end

  // Pipeline registers: accumulate stage, write history, lookup valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= 8'd0;
      last_we   <= 1'b0;
      last_addr <= 8'd0;
      last_data <= '0;
      lut_vld   <= 1'b0;
    end else begin
      s1_valid  <= accept;
      s1_addr   <= pix_in;
      last_we   <= wr_en;
      last_addr <= wr_addr;
      last_data <= wr_data;
      lut_vld   <= lut_req && (state == ST_READY);
    end
  end

  assign cdf_out = lut_vld ? rd_data : '0;

`ifdef HIST_BIN_OUT_EN
  cnt_t raw_rd_data;
  logic raw_wr_en;

  // Raw counts follow CLEAR and ACCUM writes but are left alone by SCAN
  assign raw_wr_en = wr_en && (state != ST_SCAN);

  hist_ram u_raw (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (raw_rd_data),
    .wr_en   (raw_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign bin_cnt_out = lut_vld ? raw_rd_data : '0;
`endif

endmodule

// File: tb/tb_hist_cdf_builder.sv
// Directed bench for hist_cdf_builder, run with a reduced frame of 1280
// pixels so several whole frames fit in a short run. 1280 = 5 * 256 keeps the
// ramp frame at an equal count per bin.
module tb_hist_cdf_builder;
  import hist_cdf_builder_pkg::*;

  localparam int   P      = 1280;
  localparam int   BUDGET = 4000;
  localparam cnt_t PC     = cnt_t'(P);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [7:0]       pix_in = 8'd0;
  logic             lut_req = 1'b0;
  logic [7:0]       lut_addr = 8'd0;
  logic             lut_vld;
  logic [CNT_W-1:0] cdf_out;
  logic [CNT_W-1:0] cdf_min;
  logic             cdf_rdy;
  logic             frame_release = 1'b0;
  logic [1:0]       state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard for lookups
  logic [CNT_W-1:0] exp_q[$];
  logic [7:0]       addr_q[$];
  logic             got_vld_q[$];
  logic [CNT_W-1:0] got_val_q[$];
  logic             trailing_vld;

  // Frame run results
  int   fr_hs, fr_scan;
  logic fr_after_last;
  bit   fr_timeout;

  // Release pulse results
  logic             rel_vld, rel_vld2, rel_rdy;
  logic [CNT_W-1:0] rel_val, rel_min;
  logic [1:0]       rel_state;

  // Clock
  always #5 clk = ~clk;

  hist_cdf_builder #(.FRAME_PIXELS(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_in        (pix_in),
    .lut_req       (lut_req),
    .lut_addr      (lut_addr),
    .lut_vld       (lut_vld),
    .cdf_out       (cdf_out),
    .cdf_min       (cdf_min),
    .cdf_rdy       (cdf_rdy),
    .frame_release (frame_release),
    .state_dbg     (state_dbg)
  );

  // Driver: feed one frame until READY (or abort after abort_at pixels).
  // mode 0 constant val, 1 ramp n%256, 2 pattern 7,7,7,8. gap>0 drops
  // pix_valid every gap-th cycle.
  task automatic run_frame(input int mode, input logic [7:0] val,
                           input int gap, input int abort_at);
    int n, cyc;
    bit chk_next;
    n = 0; cyc = 0; chk_next = 0;
    fr_hs = 0; fr_scan = 0; fr_after_last = 1'bx; fr_timeout = 0;
    while (state_dbg != ST_READY) begin
      @(negedge clk);
      cyc++;
      if (cyc > BUDGET) begin fr_timeout = 1; break; end
      if (state_dbg == ST_SCAN) fr_scan++;
      if (chk_next) begin fr_after_last = pix_ready; chk_next = 0; end
      if (abort_at != 0 && n >= abort_at) break;
      case (mode)
        0:       pix_in = val;
        1:       pix_in = 8'(n % 256);
        default: pix_in = ((n % 4) == 3) ? 8'd8 : 8'd7;
      endcase
      pix_valid = (gap == 0) ? 1'b1 : ((cyc % gap) != 0);
      if (pix_valid && pix_ready) begin
        fr_hs++;
        n++;
        if (n == P) chk_next = 1;
      end
    end
    pix_valid = 1'b0;
  endtask

  // Driver: issue addr_q as back-to-back lookups, capture results
  task automatic lookup_burst();
    int k;
    k = addr_q.size();
    got_vld_q.delete();
    got_val_q.delete();
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      if (i > 0) begin
        got_vld_q.push_back(lut_vld);
        got_val_q.push_back(cdf_out);
      end
      if (i < k) begin lut_req = 1'b1; lut_addr = addr_q[i]; end
      else lut_req = 1'b0;
    end
    @(negedge clk);
    trailing_vld = lut_vld;
    addr_q.delete();
  endtask

  // Driver: one-cycle release, optionally with a lookup in the same cycle
  task automatic pulse_release(input bit with_req, input logic [7:0] addr);
    @(negedge clk);
    frame_release = 1'b1;
    lut_req = with_req;
    lut_addr = addr;
    @(negedge clk);
    frame_release = 1'b0;
    lut_req = 1'b0;
    rel_vld = lut_vld; rel_val = cdf_out; rel_rdy = cdf_rdy;
    rel_state = state_dbg; rel_min = cdf_min;
    @(negedge clk);
    rel_vld2 = lut_vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (state_dbg !== ST_CLEAR) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state_dbg, ST_CLEAR); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pix_ready: got %b want 0", pix_ready); end
    n_cmp++; if (lut_vld !== 1'b0) begin n_fail++; $display("FAIL rst_lut_vld: got %b want 0", lut_vld); end
    n_cmp++; if (cdf_out !== '0) begin n_fail++; $display("FAIL rst_cdf_out: got %0d want 0", cdf_out); end
    n_cmp++; if (cdf_min !== '0) begin n_fail++; $display("FAIL rst_cdf_min: got %0d want 0", cdf_min); end
    n_cmp++; if (cdf_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_cdf_rdy: got %b want 0", cdf_rdy); end
    rst_n = 1'b1;
  endtask

  // All pixels 100 with pix_valid held high from CLEAR onward
  task automatic test_const_frame();
    run_frame(0, 8'd100, 0, 0);
    n_cmp++; if (fr_timeout) begin n_fail++; $display("FAIL const_timeout: got timeout want READY"); end
    n_cmp++; if (fr_hs != P) begin n_fail++; $display("FAIL const_handshakes: got %0d want %0d", fr_hs, P); end
    n_cmp++; if (fr_after_last !== 1'b0) begin n_fail++; $display("FAIL const_ready_after_last: got %b want 0", fr_after_last); end
    n_cmp++; if (fr_scan != 256) begin n_fail++; $display("FAIL const_scan_cycles: got %0d want 256", fr_scan); end
    n_cmp++; if (cdf_rdy !== 1'b1) begin n_fail++; $display("FAIL const_cdf_rdy: got %b want 1", cdf_rdy); end
    n_cmp++; if (cdf_min !== PC) begin n_fail++; $display("FAIL const_cdf_min: got %0d want %0d", cdf_min, PC); end
    addr_q.push_back(8'd99);  exp_q.push_back('0);
    addr_q.push_back(8'd100); exp_q.push_back(PC);
    addr_q.push_back(8'd255); exp_q.push_back(PC);
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL const_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    n_cmp++; if (trailing_vld !== 1'b0) begin n_fail++; $display("FAIL const_lut_trailing: got %b want 0", trailing_vld); end
  endtask

  // Release drops cdf_rdy, cdf_min holds; lookups in CLEAR are ignored
  task automatic test_release();
    pulse_release(1'b0, 8'd0);
    n_cmp++; if (rel_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_cdf_rdy: got %b want 0", rel_rdy); end
    n_cmp++; if (rel_state !== ST_CLEAR) begin n_fail++; $display("FAIL rel_state: got %0d want %0d", rel_state, ST_CLEAR); end
    n_cmp++; if (rel_min !== PC) begin n_fail++; $display("FAIL rel_cdf_min_hold: got %0d want %0d", rel_min, PC); end
    @(negedge clk); lut_req = 1'b1; lut_addr = 8'd100;
    @(negedge clk); lut_req = 1'b0;
    n_cmp++; if (lut_vld !== 1'b0) begin n_fail++; $display("FAIL clear_lut_ignored: got %b want 0", lut_vld); end
  endtask

  // Release during ACCUM must not disturb the frame
  task automatic test_release_ignored();
    int cyc;
    cyc = 0;
    while (state_dbg != ST_ACCUM && cyc < BUDGET) begin @(negedge clk); cyc++; end
    n_cmp++; if (state_dbg !== ST_ACCUM) begin n_fail++; $display("FAIL accum_wait: got state %0d want %0d", state_dbg, ST_ACCUM); end
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    n_cmp++; if (state_dbg !== ST_ACCUM || pix_ready !== 1'b1) begin n_fail++; $display("FAIL accum_release_ignored: got state=%0d ready=%b want state=%0d ready=1", state_dbg, pix_ready, ST_ACCUM); end
  endtask

  // Ramp frame with input gaps: 5 per bin, CDF[k] = 5*(k+1)
  task automatic test_ramp_frame();
    run_frame(1, 8'd0, 5, 0);
    n_cmp++; if (fr_timeout) begin n_fail++; $display("FAIL ramp_timeout: got timeout want READY"); end
    n_cmp++; if (fr_hs != P) begin n_fail++; $display("FAIL ramp_handshakes: got %0d want %0d", fr_hs, P); end
    n_cmp++; if (cdf_min !== cnt_t'(5)) begin n_fail++; $display("FAIL ramp_cdf_min: got %0d want 5", cdf_min); end
    addr_q.push_back(8'd0);   exp_q.push_back(cnt_t'(5));
    addr_q.push_back(8'd1);   exp_q.push_back(cnt_t'(10));
    addr_q.push_back(8'd127); exp_q.push_back(cnt_t'(640));
    addr_q.push_back(8'd255); exp_q.push_back(cnt_t'(1280));
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ramp_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  // Three consecutive lookups give three consecutive valid results
  task automatic test_back_to_back();
    addr_q.push_back(8'd0);   exp_q.push_back(cnt_t'(5));
    addr_q.push_back(8'd255); exp_q.push_back(cnt_t'(1280));
    addr_q.push_back(8'd100); exp_q.push_back(cnt_t'(505));
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    n_cmp++; if (trailing_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_trailing: got %b want 0", trailing_vld); end
  endtask

  // Release together with a lookup: lookup still completes
  task automatic test_release_with_lookup();
    pulse_release(1'b1, 8'd100);
    n_cmp++; if (rel_vld !== 1'b1 || rel_val !== cnt_t'(505)) begin n_fail++; $display("FAIL rel_lut: got vld=%b cdf=%0d want vld=1 cdf=505", rel_vld, rel_val); end
    n_cmp++; if (rel_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_lut_cdf_rdy: got %b want 0", rel_rdy); end
    n_cmp++; if (rel_vld2 !== 1'b0) begin n_fail++; $display("FAIL rel_lut_after: got %b want 0", rel_vld2); end
  endtask

  // 7,7,7,8 back-to-back: same-bin pixels on adjacent cycles
  task automatic test_forwarding();
    run_frame(2, 8'd0, 0, 0);
    n_cmp++; if (fr_timeout) begin n_fail++; $display("FAIL fwd_timeout: got timeout want READY"); end
    n_cmp++; if (cdf_min !== cnt_t'(960)) begin n_fail++; $display("FAIL fwd_cdf_min: got %0d want 960", cdf_min); end
    addr_q.push_back(8'd6); exp_q.push_back('0);
    addr_q.push_back(8'd7); exp_q.push_back(cnt_t'(960));
    addr_q.push_back(8'd8); exp_q.push_back(PC);
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fwd_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  // Second frame of all zeros after release
  task automatic test_zero_frame();
    pulse_release(1'b0, 8'd0);
    run_frame(0, 8'd0, 0, 0);
    n_cmp++; if (fr_timeout) begin n_fail++; $display("FAIL zero_timeout: got timeout want READY"); end
    n_cmp++; if (cdf_min !== PC) begin n_fail++; $display("FAIL zero_cdf_min: got %0d want %0d", cdf_min, PC); end
    addr_q.push_back(8'd0);   exp_q.push_back(PC);
    addr_q.push_back(8'd255); exp_q.push_back(PC);
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL zero_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  // Reset in the middle of ACCUM, then a clean frame of 50
  task automatic test_reset_mid_frame();
    pulse_release(1'b0, 8'd0);
    run_frame(0, 8'd49, 0, 600);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_CLEAR || cdf_min !== '0 || cdf_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got state=%0d min=%0d rdy=%b want state=0 min=0 rdy=0", state_dbg, cdf_min, cdf_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'd50, 0, 0);
    n_cmp++; if (fr_timeout) begin n_fail++; $display("FAIL midrst_timeout: got timeout want READY"); end
    n_cmp++; if (cdf_min !== PC) begin n_fail++; $display("FAIL midrst_cdf_min: got %0d want %0d", cdf_min, PC); end
    addr_q.push_back(8'd49); exp_q.push_back('0);
    addr_q.push_back(8'd50); exp_q.push_back(PC);
    lookup_burst();
    for (int i = 0; i < got_val_q.size(); i++) begin
      n_cmp++;
      if (got_vld_q[i] !== 1'b1 || got_val_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_lut[%0d]: got vld=%b cdf=%0d want vld=1 cdf=%0d", i, got_vld_q[i], got_val_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_release();
    test_release_ignored();
    test_ramp_frame();
    test_back_to_back();
    test_release_with_lookup();
    test_forwarding();
    test_zero_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
